control_unit_param: RTL and testbench
=====================================

Name: control_unit_param

Overview:
- Parametrised next-generation sequencer for the team's shared-datapath ALU (A, Q, Q[-1], M registers, adder/subtractor, shifter).
- Executes ADD, SUB, Booth radix-2 MUL and restoring DIV on WIDTH-bit operands.
- Owns the iteration counter internally and latches the opcode at start.
- Drives an 11-bit control word into the datapath and reports completion.

Parameters:
- WIDTH, 8, operand width in bits (minimum 2); also the MUL/DIV iteration count.
- CNT_W, $clog2(WIDTH)+1, internal counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- s  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled only with an accepted start.
- start  input  1  operation request; level-sampled in IDLE.
- q0  input  1  datapath Q[0].
- q_1  input  1  datapath Q[-1].
- a_msb  input  1  datapath A[WIDTH] sign bit.
- c  output  11  control word (bit map below).
- cnt  output  CNT_W  current iteration counter (debug/observation).
- busy  output  1  high in every state except IDLE.
- finish  output  1  one-cycle pulse in DONE.

Behaviour:
- Control word bit map:
  - c0 LOAD_Q (inbus->Q)
  - c1 LOAD_M (inbus->M)
  - c2 ADD (A<=A+M)
  - c3 SUB (A<=A-M)
  - c4 ASHR {A,Q,Q[-1]}
  - c5 SHL {A,Q}
  - c6 SET_Q0
  - c7 OUT_A
  - c8 OUT_Q
  - c9 LOAD_A (inbus->A)
  - c10 CLR (A<=0, Q[-1]<=0)
- c is a combinational decode of state plus q0, q_1 and a_msb (Mealy only in BOOTH and DIV_CHK). All bits not listed for a state are 0.
- States: IDLE, LOAD_X, LOAD_Y, ADDSUB, BOOTH, MUL_SHIFT, DIV_SHL, DIV_SUB, DIV_CHK, OUT_A, OUT_Q, DONE.
- IDLE: c=0. On start=1, latch s into op_r and go to LOAD_X. start is ignored while busy=1.
- LOAD_X: ADD/SUB assert c9; MUL/DIV assert c0 and c10. Next state is LOAD_Y.
- LOAD_Y: assert c1 and load cnt<=WIDTH. ADD/SUB go to ADDSUB; MUL goes to BOOTH; DIV goes to DIV_SHL.
- ADDSUB: assert c2 (ADD) or c3 (SUB), then go to OUT_A.
- BOOTH:
  - {q0,q_1}=01: assert c2, go to MUL_SHIFT.
  - {q0,q_1}=10: assert c3, go to MUL_SHIFT.
  - 00 or 11: assert c4 and decrement cnt in this cycle (shift-only fast path). Go to OUT_A if cnt was 1, else stay in BOOTH.
- MUL_SHIFT: assert c4 and decrement cnt. Go to OUT_A if cnt was 1, else go to BOOTH.
- DIV_SHL: assert c5, go to DIV_SUB.
- DIV_SUB: assert c3, go to DIV_CHK.
- DIV_CHK: if a_msb=1 assert c2 (restore), else assert c6. Decrement cnt. Go to OUT_Q if cnt was 1, else go to DIV_SHL.
- Output order:
  - MUL: OUT_A (c7) -> OUT_Q (c8) -> DONE.
  - DIV: OUT_Q (quotient) -> OUT_A (remainder) -> DONE.
  - ADD/SUB: OUT_A -> DONE.
- DONE: finish=1 for one cycle, c=0, then IDLE. If start=1 in DONE it is ignored; it is accepted on the following IDLE cycle.
- Latency from the start-sampling edge to the finish cycle:
  - ADD/SUB: 5 cycles.
  - MUL: between 2+WIDTH+3 and 2+2*WIDTH+3 cycles, depending on the Booth pairs.
  - DIV: 2+3*WIDTH+3 cycles.
- cnt never wraps below 0. It holds its value outside LOAD_Y and the decrementing states, and is 0 at reset.
- Reset (any time, including mid-operation): state=IDLE, op_r=00, cnt=0, c=0, busy=0, finish=0, asynchronously.
- Changes on s after start acceptance have no effect on the running operation.

Optional Feature:
- Macro: DIVZERO_CHECK_EN.
- When defined:
  - Adds input m_zero (1, divisor==0 from datapath) and output div_err (1).
  - In LOAD_Y with op_r=DIV and m_zero=1, skip all iterations and go directly to DONE with div_err=1. No c2..c8 asserted.
  - div_err is held until the next accepted start; reset clears it to 0.
- When undefined:
  - Neither port exists.
  - Division by zero runs the normal WIDTH iterations (quotient all ones, per restoring algorithm).

Test Plan:
- WIDTH=8, reset released, s=00, start=1 for one cycle -> c9, c1, c2, c7 in cycles 1-4; finish=1 in cycle 5; busy high in cycles 1-5.
- WIDTH=8, s=10, q0=0 and q_1=0 held -> 8 consecutive BOOTH cycles with c=0x010 and cnt 8->0; OUT_A in cycle 11, OUT_Q in cycle 12, finish in cycle 13.
- WIDTH=8, s=10, q0=1 and q_1=0 held -> alternating c3/c4 for 16 cycles; finish in cycle 21.
- WIDTH=8, s=11, a_msb=1 in even iterations -> c2 in DIV_CHK for those iterations and c6 otherwise; OUT_Q in cycle 27, OUT_A in cycle 28, finish in cycle 29.
- Pull rst_b low during MUL iteration 4 -> c=0, busy=0, cnt=0 immediately; a new start after release runs a full operation.
- s changed 10->00 mid-MUL and start pulsed while busy -> no effect; MUL completes normally. With DIVZERO_CHECK_EN defined, s=11 and m_zero=1 -> finish in cycle 3, div_err=1.

Source files
------------

// File: rtl/control_unit_param_if.sv
// Sequencer <-> datapath/requester bundle for control_unit_param.
// DIVZERO_CHECK_EN adds m_zero and div_err.
interface control_unit_param_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]       s;
    logic             start;
    logic             q0;
    logic             q_1;
    logic             a_msb;
    logic [10:0]      c;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             finish;
`ifdef DIVZERO_CHECK_EN
    logic             m_zero;
    logic             div_err;

    modport master (output s, start, q0, q_1, a_msb, m_zero,
                    input  c, cnt, busy, finish, div_err);
    modport slave  (input  s, start, q0, q_1, a_msb, m_zero,
                    output c, cnt, busy, finish, div_err);
`else
    modport master (output s, start, q0, q_1, a_msb,
                    input  c, cnt, busy, finish);
    modport slave  (input  s, start, q0, q_1, a_msb,
                    output c, cnt, busy, finish);
`endif
endinterface

// File: rtl/control_unit_param.sv
// ADD/SUB/Booth MUL/restoring DIV sequencer driving an 11-bit datapath control word.
// Optional divide-by-zero early exit under DIVZERO_CHECK_EN.
module control_unit_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    control_unit_param_if.slave  bus
);
    localparam int C_LDQ = 0, C_LDM = 1, C_ADD = 2, C_SUB = 3, C_ASHR = 4, C_SHL = 5,
                   C_SETQ = 6, C_OUTA = 7, C_OUTQ = 8, C_LDA = 9, C_CLR = 10;
    localparam logic [1:0] OP_MUL = 2'b10, OP_DIV = 2'b11;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        IDLE, LOAD_X, LOAD_Y, ADDSUB, BOOTH, MUL_SHIFT,
        DIV_SHL, DIV_SUB, DIV_CHK, OUT_A, OUT_Q, DONE
    } state_t;

    state_t           state, nxt;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] cnt_r, cnt_nxt, cnt_dec;
    logic [10:0]      ctl;
    logic             last, accept;

    assign accept  = (state == IDLE) && bus.start;
    // Saturating decrement keeps cnt from wrapping if ever entered at 0.
    assign cnt_dec = (cnt_r != '0) ? cnt_r - ONE : cnt_r;
    assign last    = (cnt_r <= ONE);

`ifdef DIVZERO_CHECK_EN
    logic err_set, div_err_r;
    assign bus.div_err = div_err_r;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)       div_err_r <= 1'b0;
        else if (accept)  div_err_r <= 1'b0;
        else if (err_set) div_err_r <= 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            op_r  <= 2'b00;
            cnt_r <= '0;
        end else begin
            state <= nxt;
            cnt_r <= cnt_nxt;
            if (accept) op_r <= bus.s;
        end
    end

    always_comb begin
        nxt     = state;
        ctl     = '0;
        cnt_nxt = cnt_r;
`ifdef DIVZERO_CHECK_EN
        err_set = 1'b0;
`endif
        unique case (state)
            IDLE:   if (bus.start) nxt = LOAD_X;
            LOAD_X: begin
                if (op_r[1]) begin
                    ctl[C_LDQ] = 1'b1;
                    ctl[C_CLR] = 1'b1;
                end else begin
                    ctl[C_LDA] = 1'b1;
                end
                nxt = LOAD_Y;
            end
            LOAD_Y: begin
                ctl[C_LDM] = 1'b1;
                cnt_nxt    = CNT_W'(WIDTH);
                if (op_r == OP_MUL)      nxt = BOOTH;
                else if (op_r == OP_DIV) begin
`ifdef DIVZERO_CHECK_EN
                    if (bus.m_zero) begin
                        nxt     = DONE;
                        err_set = 1'b1;
                    end else begin
                        nxt = DIV_SHL;
                    end
`else
                    nxt = DIV_SHL;
`endif
                end else                 nxt = ADDSUB;
            end
            ADDSUB: begin
                ctl[op_r[0] ? C_SUB : C_ADD] = 1'b1;
                nxt = OUT_A;
            end
            BOOTH: begin
                if ({bus.q0, bus.q_1} == 2'b01) begin
                    ctl[C_ADD] = 1'b1;
                    nxt = MUL_SHIFT;
                end else if ({bus.q0, bus.q_1} == 2'b10) begin
                    ctl[C_SUB] = 1'b1;
                    nxt = MUL_SHIFT;
                end else begin
                    // Equal Booth pair: shift without an add/sub cycle.
                    ctl[C_ASHR] = 1'b1;
                    cnt_nxt     = cnt_dec;
                    nxt         = last ? OUT_A : BOOTH;
                end
            end
            MUL_SHIFT: begin
                ctl[C_ASHR] = 1'b1;
                cnt_nxt     = cnt_dec;
                nxt         = last ? OUT_A : BOOTH;
            end
            DIV_SHL: begin
                ctl[C_SHL] = 1'b1;
                nxt = DIV_SUB;
            end
            DIV_SUB: begin
                ctl[C_SUB] = 1'b1;
                nxt = DIV_CHK;
            end
            DIV_CHK: begin
                if (bus.a_msb) ctl[C_ADD]  = 1'b1;
                else           ctl[C_SETQ] = 1'b1;
                cnt_nxt = cnt_dec;
                nxt     = last ? OUT_Q : DIV_SHL;
            end
            OUT_A: begin
                ctl[C_OUTA] = 1'b1;
                nxt = (op_r == OP_MUL) ? OUT_Q : DONE;
            end
            OUT_Q: begin
                ctl[C_OUTQ] = 1'b1;
                nxt = (op_r == OP_DIV) ? OUT_A : DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign bus.c      = ctl;
    assign bus.cnt    = cnt_r;
    assign bus.busy   = (state != IDLE);
    assign bus.finish = (state == DONE);
endmodule

// File: tb/tb_control_unit_param.sv
// Directed bench for control_unit_param at WIDTH=8; expected control words are hand-derived.
module tb_control_unit_param;
    logic clk = 1'b0;
    logic rst_b;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    control_unit_param_if #(.WIDTH(8)) bus ();
    control_unit_param #(.WIDTH(8)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue start at a negedge; returns in cycle 1 (LOAD_X) with start released.
    task automatic go(input logic [1:0] op);
        bus.s     = op;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0;
        bus.s = 2'b00; bus.start = 1'b0; bus.q0 = 1'b0; bus.q_1 = 1'b0; bus.a_msb = 1'b0;
`ifdef DIVZERO_CHECK_EN
        bus.m_zero = 1'b0;
`endif
        repeat (2) step();
        chk("rst_c", 32'(bus.c), 32'h000);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_fin", 32'(bus.finish), 0);
        chk("rst_cnt", 32'(bus.cnt), 0);
        rst_b = 1'b1;
        step();

        // ADD
        go(2'b00);
        chk("add_c1", 32'(bus.c), 32'h200);
        chk("add_busy1", 32'(bus.busy), 1);
        step(); chk("add_c2", 32'(bus.c), 32'h002);
        step(); chk("add_c3", 32'(bus.c), 32'h004);
        step(); chk("add_c4", 32'(bus.c), 32'h080);
        chk("add_busy4", 32'(bus.busy), 1);
        step(); chk("add_fin5", 32'(bus.finish), 1);
        chk("add_c5", 32'(bus.c), 32'h000);
        chk("add_busy5", 32'(bus.busy), 1);
        step(); chk("add_idle_busy", 32'(bus.busy), 0);
        chk("add_idle_fin", 32'(bus.finish), 0);

        // MUL, Booth pair 00 throughout; s/start disturbed mid-run
        go(2'b10);
        chk("mul0_c1", 32'(bus.c), 32'h401);
        step(); chk("mul0_c2", 32'(bus.c), 32'h002);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("mul0_booth%0d_c", i), 32'(bus.c), 32'h010);
            chk($sformatf("mul0_booth%0d_cnt", i), 32'(bus.cnt), 32'(8 - i));
            if (i == 2) begin bus.s = 2'b00; bus.start = 1'b1; end
            if (i == 3) bus.start = 1'b0;
        end
        step(); chk("mul0_c11", 32'(bus.c), 32'h080);
        chk("mul0_cnt11", 32'(bus.cnt), 0);
        step(); chk("mul0_c12", 32'(bus.c), 32'h100);
        step(); chk("mul0_fin13", 32'(bus.finish), 1);
        // start raised in DONE must wait for the following IDLE cycle
        bus.s = 2'b10; bus.start = 1'b1; bus.q0 = 1'b1; bus.q_1 = 1'b0;
        step(); chk("done_start_busy", 32'(bus.busy), 0);
        chk("done_start_c", 32'(bus.c), 32'h000);
        step(); bus.start = 1'b0;

        // MUL, Booth pair 10 throughout: alternating SUB / ASHR
        chk("mul1_c1", 32'(bus.c), 32'h401);
        step(); chk("mul1_c2", 32'(bus.c), 32'h002);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("mul1_it%0d_sub", k), 32'(bus.c), 32'h008);
            chk($sformatf("mul1_it%0d_cntb", k), 32'(bus.cnt), 32'(9 - k));
            step();
            chk($sformatf("mul1_it%0d_shr", k), 32'(bus.c), 32'h010);
        end
        step(); chk("mul1_c19", 32'(bus.c), 32'h080);
        step(); chk("mul1_c20", 32'(bus.c), 32'h100);
        step(); chk("mul1_fin21", 32'(bus.finish), 1);
        bus.q0 = 1'b0;
        step();

        // DIV, a_msb=1 in even iterations
        go(2'b11);
        chk("div_c1", 32'(bus.c), 32'h401);
        step(); chk("div_c2", 32'(bus.c), 32'h002);
        for (int k = 1; k <= 8; k++) begin
            step(); chk($sformatf("div_it%0d_shl", k), 32'(bus.c), 32'h020);
            step(); chk($sformatf("div_it%0d_sub", k), 32'(bus.c), 32'h008);
            bus.a_msb = (k % 2 == 0);
            step();
            chk($sformatf("div_it%0d_chk", k), 32'(bus.c), (k % 2 == 0) ? 32'h004 : 32'h040);
            chk($sformatf("div_it%0d_cnt", k), 32'(bus.cnt), 32'(9 - k));
            bus.a_msb = 1'b0;
        end
        step(); chk("div_c27", 32'(bus.c), 32'h100);
        step(); chk("div_c28", 32'(bus.c), 32'h080);
        step(); chk("div_fin29", 32'(bus.finish), 1);
        chk("div_cnt29", 32'(bus.cnt), 0);
        step();

        // Reset during MUL iteration 4, then a full SUB
        go(2'b10);
        repeat (5) step();
        chk("rstmid_pre_cnt", 32'(bus.cnt), 5);
        #1 rst_b = 1'b0;
        #1;
        chk("rstmid_c", 32'(bus.c), 32'h000);
        chk("rstmid_busy", 32'(bus.busy), 0);
        chk("rstmid_cnt", 32'(bus.cnt), 0);
        chk("rstmid_fin", 32'(bus.finish), 0);
        step(); rst_b = 1'b1;
        step();
        go(2'b01);
        chk("sub_c1", 32'(bus.c), 32'h200);
        step(); chk("sub_c2", 32'(bus.c), 32'h002);
        step(); chk("sub_c3", 32'(bus.c), 32'h008);
        step(); chk("sub_c4", 32'(bus.c), 32'h080);
        step(); chk("sub_fin5", 32'(bus.finish), 1);
        step();

`ifdef DIVZERO_CHECK_EN
        bus.m_zero = 1'b1;
        go(2'b11);
        chk("dz_c1", 32'(bus.c), 32'h401);
        step(); chk("dz_c2", 32'(bus.c), 32'h002);
        chk("dz_err2", 32'(bus.div_err), 0);
        step(); chk("dz_fin3", 32'(bus.finish), 1);
        chk("dz_err3", 32'(bus.div_err), 1);
        chk("dz_c3", 32'(bus.c), 32'h000);
        step(); chk("dz_err_hold", 32'(bus.div_err), 1);
        bus.m_zero = 1'b0;
        go(2'b00);
        chk("dz_err_clr", 32'(bus.div_err), 0);
        repeat (5) step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
